// File: rtl/frame_sram_writer_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Constants and types shared by the frame SRAM writer and the rotation
// adapter that reads the same SRAM. The adapter derives its read addressing
// from IMG_W/IMG_H/N/PIX_W so both sides agree on the frame layout.
//   IMG_W, IMG_H : frame geometry in pixels
//   N            : pixels per frame
//   PIX_W        : pixel index width (2**PIX_W >= N)
//   DATA_W       : pixel width
//   FCNT_W       : completed-frame counter width
//   bank_state_e : life cycle of one SRAM bank
// -----------------------------------------------------------------------------
package frame_pkg;

  localparam int IMG_W  = 1024;
  localparam int IMG_H  = 1024;
  localparam int N      = IMG_W * IMG_H;
  localparam int PIX_W  = 20;
  localparam int DATA_W = 8;
  localparam int FCNT_W = 16;

  // EMPTY -> FILLING -> PEND -> FULL -> EMPTY
  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_PEND    = 2'd2,
    BANK_FULL    = 2'd3
  } bank_state_e;

  // A bank that is PEND or FULL holds a closed frame and must not be written.
  function automatic logic bank_occupied(input bank_state_e st);
    return (st == BANK_PEND) || (st == BANK_FULL);
  endfunction

endpackage

// File: rtl/frame_sram_writer_if.sv
// -----------------------------------------------------------------------------
// frame_sram_writer_if
// Raster pixel stream (valid/ready) feeding the frame SRAM writer.
//   s_valid : source has a pixel
//   s_ready : writer can take a pixel
//   s_data  : pixel, raster order
//   s_last  : final pixel of a frame
// master = pixel source, slave = writer.
// -----------------------------------------------------------------------------
interface frame_sram_writer_if #(
  parameter int DATA_W = frame_pkg::DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/frame_sram_writer_bank_tracker.sv
// -----------------------------------------------------------------------------
// bank_tracker
// Owns the ping-pong bank bookkeeping between the writer and the rotation
// reader: how many banks are full, whether a just-closed bank is waiting for
// its last SRAM write to land, which bank the reader must consume next, and
// the flow-control term that stalls the pixel stream.
//   clk, rst        : clock, asynchronous active-low reset
//   i_accept        : a pixel beat is accepted this cycle
//   i_close         : the accepted beat closes the current frame
//   i_wr_bank       : bank currently being written
//   i_rd_done       : reader finished o_rd_bank (single-cycle pulse)
//   o_s_ready       : fewer than two banks are occupied by closed frames
//   o_frame_ready   : at least one full bank awaits the reader
//   o_rd_bank       : oldest full bank
//   o_pend          : a closed frame commits at the next edge
// -----------------------------------------------------------------------------
module bank_tracker
  import frame_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_accept,
  input  logic i_close,
  input  logic i_wr_bank,
  input  logic i_rd_done,
  output logic o_s_ready,
  output logic o_frame_ready,
  output logic o_rd_bank,
  output logic o_pend
);

  logic [1:0]  r_full_cnt;
  logic        r_pend;
  logic        r_rd_bank;
  bank_state_e r_bank_st [2];

  logic        w_rd_ok;
  logic [1:0]  w_full_cnt_nxt;

  // Reader handshake qualification and next full-bank count.
  always_comb begin
    w_rd_ok        = i_rd_done & (r_full_cnt != 2'd0);
    w_full_cnt_nxt = r_full_cnt;
    // A commit and an honoured rd_done in the same cycle cancel out.
    case ({r_pend, w_rd_ok})
      2'b10:   w_full_cnt_nxt = r_full_cnt + 2'd1;
      2'b01:   w_full_cnt_nxt = r_full_cnt - 2'd1;
      default: w_full_cnt_nxt = r_full_cnt;
    endcase
  end

  // Bank bookkeeping state: counters, read pointer and per-bank life cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full_cnt <= 2'd0;
      r_pend     <= 1'b0;
      r_rd_bank  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        r_bank_st[b] <= BANK_EMPTY;
      end
    end else begin
      r_full_cnt <= w_full_cnt_nxt;
      // A pending commit always resolves one edge later, so pend simply
      // follows the close strobe, even when a one-beat frame closes while
      // the previous one is still committing.
      r_pend     <= i_close;
      if (w_rd_ok) begin
        r_rd_bank <= ~r_rd_bank;
      end
      for (int b = 0; b < 2; b++) begin
        case (r_bank_st[b])
          BANK_EMPTY: begin
            if (i_accept && (i_wr_bank == 1'(b))) begin
              r_bank_st[b] <= i_close ? BANK_PEND : BANK_FILLING;
            end
          end
          BANK_FILLING: begin
            if (i_close && (i_wr_bank == 1'(b))) begin
              r_bank_st[b] <= BANK_PEND;
            end
          end
          BANK_PEND: begin
            r_bank_st[b] <= BANK_FULL;
          end
          BANK_FULL: begin
            if (w_rd_ok && (r_rd_bank == 1'(b))) begin
              r_bank_st[b] <= BANK_EMPTY;
            end
          end
          default: begin
            r_bank_st[b] <= BANK_EMPTY;
          end
        endcase
      end
    end
  end

  // Flow control counts the pending bank as occupied so the stall is raised
  // in the cycle right after the close that fills the second bank.
  assign o_s_ready     = ({1'b0, r_full_cnt} + {2'b00, r_pend}) < 3'd2;
  assign o_frame_ready = (r_full_cnt != 2'd0);
  assign o_rd_bank     = r_rd_bank;
  assign o_pend        = r_pend;

endmodule

// File: rtl/frame_sram_writer.sv
// -----------------------------------------------------------------------------
// frame_sram_writer
// Ping-pong frame writer: accepts a raster pixel stream and writes each frame
// into one of two SRAM banks, handing completed banks to the rotation reader
// through frame_ready / rd_bank / rd_done.
//   clk, rst    : clock, asynchronous active-low reset
//   s_if        : pixel stream (slave side)
//   mem_we      : SRAM write strobe (registered)
//   mem_addr    : {bank, pixel index} (registered)
//   mem_wdata   : SRAM write data (registered)
//   frame_ready : at least one full bank awaits the reader
//   rd_bank     : bank the reader must consume
//   rd_done     : reader finished rd_bank (single-cycle pulse)
//   frame_cnt   : frames completed, wraps
//   err_short   : sticky, s_last arrived before the final pixel
//   err_long    : sticky, final pixel arrived without s_last
// -----------------------------------------------------------------------------
module frame_sram_writer #(
  parameter int IMG_W  = frame_pkg::IMG_W,
  parameter int IMG_H  = frame_pkg::IMG_H,
  parameter int DATA_W = frame_pkg::DATA_W,
  parameter int PIX_W  = frame_pkg::PIX_W,
  parameter int FCNT_W = frame_pkg::FCNT_W
) (
  input  logic                clk,
  input  logic                rst,
  frame_sram_writer_if.slave  s_if,
  output logic                mem_we,
  output logic [PIX_W:0]      mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                frame_ready,
  output logic                rd_bank,
  input  logic                rd_done,
  output logic [FCNT_W-1:0]   frame_cnt,
  output logic                err_short,
  output logic                err_long
);

  localparam int             N        = IMG_W * IMG_H;
  localparam logic [PIX_W-1:0] LAST_IDX = PIX_W'(N - 1);

  logic              r_mem_we;
  logic [PIX_W:0]    r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [PIX_W-1:0]  r_pix_idx;
  logic              r_wr_bank;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_err_short;
  logic              r_err_long;

  logic              w_s_ready;
  logic              w_accept;
  logic              w_last_idx;
  logic              w_close;
  logic              w_pend;

  assign w_accept   = s_if.s_valid & w_s_ready;
  assign w_last_idx = (r_pix_idx == LAST_IDX);
  // Either the index reaching N-1 or s_last ends the frame; a mismatch
  // between the two is only flagged, never allowed to overrun the bank.
  assign w_close    = w_accept & (w_last_idx | s_if.s_last);

  bank_tracker u_bank_tracker (
    .clk           (clk),
    .rst           (rst),
    .i_accept      (w_accept),
    .i_close       (w_close),
    .i_wr_bank     (r_wr_bank),
    .i_rd_done     (rd_done),
    .o_s_ready     (w_s_ready),
    .o_frame_ready (frame_ready),
    .o_rd_bank     (rd_bank),
    .o_pend        (w_pend)
  );

  // Write pipeline, pixel counter, bank select, frame counter and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_pix_idx   <= '0;
      r_wr_bank   <= 1'b0;
      r_frame_cnt <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_mem_we <= w_accept;
      if (w_accept) begin
        r_mem_addr  <= {r_wr_bank, r_pix_idx};
        r_mem_wdata <= s_if.s_data;
      end
      if (w_close) begin
        r_pix_idx <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else if (w_accept) begin
        r_pix_idx <= r_pix_idx + PIX_W'(1);
      end
      if (w_accept && s_if.s_last && !w_last_idx) begin
        r_err_short <= 1'b1;
      end
      if (w_accept && w_last_idx && !s_if.s_last) begin
        r_err_long <= 1'b1;
      end
      // Counted when the frame commits, i.e. after its last write landed.
      if (w_pend) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
    end
  end

  assign s_if.s_ready = w_s_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign frame_cnt    = r_frame_cnt;
  assign err_short    = r_err_short;
  assign err_long     = r_err_long;

endmodule

// File: tb/tb_frame_sram_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_sram_writer
// Directed scenarios plus randomized traffic for frame_sram_writer with a
// 4x4 frame, checked against a queue-based reference model of the banks.
// -----------------------------------------------------------------------------
module tb_frame_sram_writer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int N      = IMG_W * IMG_H;
  localparam int DATA_W = 8;
  localparam int PIX_W  = 4;
  localparam int FCNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_sram_writer_if #(.DATA_W(DATA_W)) s_if ();

  logic              mem_we;
  logic [PIX_W:0]    mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              frame_ready;
  logic              rd_bank;
  logic              rd_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              err_short;
  logic              err_long;

  frame_sram_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .PIX_W(PIX_W), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk), .rst(rst), .s_if(s_if),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .frame_ready(frame_ready), .rd_bank(rd_bank), .rd_done(rd_done),
    .frame_cnt(frame_cnt), .err_short(err_short), .err_long(err_long)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: closed frames waiting for the reader live in a FIFO of
  // bank numbers; a frame closed this cycle sits in m_pend for one edge.
  int full_q[$];
  int m_pend, m_pend_bank;
  int m_bank, m_idx, m_rd_bank, m_fcnt;
  int m_we, m_addr, m_wdata, m_es, m_el;

  task automatic model_reset();
    full_q.delete();
    m_pend = 0; m_pend_bank = 0; m_bank = 0; m_idx = 0; m_rd_bank = 0;
    m_fcnt = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_es = 0; m_el = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"},     32'(s_if.s_ready), 32'd1);
    chk({tag, "_mem_we"},      32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"},    32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"},   32'(mem_wdata), 32'd0);
    chk({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
    chk({tag, "_rd_bank"},     32'(rd_bank), 32'd0);
    chk({tag, "_frame_cnt"},   32'(frame_cnt), 32'd0);
    chk({tag, "_err_short"},   32'(err_short), 32'd0);
    chk({tag, "_err_long"},    32'(err_long), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_last = 1'b0; rd_done = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check flow-control outputs, advance the
  // model by the same edge and check registered outputs after it.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit l,
                      input bit rdd, output bit acc);
    int occ;
    bit rd_ok;
    @(negedge clk);
    s_if.s_valid = v; s_if.s_data = d; s_if.s_last = l; rd_done = rdd;
    #1;
    occ = full_q.size() + m_pend;
    chk("s_ready",     32'(s_if.s_ready), 32'(occ < 2));
    chk("frame_ready", 32'(frame_ready), 32'(full_q.size() != 0));
    chk("rd_bank",     32'(rd_bank), 32'(m_rd_bank));
    acc   = v && (occ < 2);
    rd_ok = rdd && (full_q.size() != 0);
    if (rd_ok) begin
      void'(full_q.pop_front());
      m_rd_bank ^= 1;
    end
    if (m_pend != 0) begin
      full_q.push_back(m_pend_bank);
      m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
      m_pend = 0;
    end
    m_we = acc ? 1 : 0;
    if (acc) begin
      m_addr  = m_bank * N + m_idx;
      m_wdata = int'(d);
      if (l && m_idx != N - 1) m_es = 1;
      if (!l && m_idx == N - 1) m_el = 1;
      if (l || m_idx == N - 1) begin
        m_pend = 1; m_pend_bank = m_bank; m_bank ^= 1; m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
    chk("mem_we", 32'(mem_we), 32'(m_we));
    if (m_we != 0) begin
      chk("mem_addr",  32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("err_short", 32'(err_short), 32'(m_es));
    chk("err_long",  32'(err_long), 32'(m_el));
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input bit l);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      step(1'b1, d, l, 1'b0, acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Sends beats base..base+len-1; s_last on the beat at position last_at
  // (0-based), or on none when last_at is negative.
  task automatic send_frame(input int base, input int len, input int last_at);
    for (int i = 0; i < len; i++) begin
      send_beat(8'(base + i), (i == last_at));
    end
  endtask

  task automatic idle(input int n, input bit rdd);
    bit acc;
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, 1'b0, rdd, acc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst = 1'b0;
    s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_last = 1'b0; rd_done = 1'b0;
    model_reset();

    // 1. reset, then reset in the middle of a frame
    do_reset("t1_por");
    idle(2, 1'b0);
    send_frame(8'h30, 5, -1);
    do_reset("t1_mid");
    send_beat(8'h55, 1'b0);
    chk("t1_restart_addr", 32'(mem_addr), 32'h00);

    // 2. one full frame, data equal to address
    do_reset("t2");
    send_frame(0, N, N - 1);
    idle(1, 1'b0);
    chk("t2_frame_ready", 32'(frame_ready), 32'd1);
    chk("t2_rd_bank",     32'(rd_bank), 32'd0);
    chk("t2_frame_cnt",   32'(frame_cnt), 32'd1);

    // 3. both banks filled, third frame stalls until rd_done
    do_reset("t3");
    send_frame(8'h00, N, N - 1);
    send_frame(8'h10, N, N - 1);
    chk("t3_stall", 32'(s_if.s_ready), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA0, 1'b0, 1'b0, acc);
    step(1'b1, 8'hA0, 1'b0, 1'b1, acc);
    chk("t3_rd_bank", 32'(rd_bank), 32'd1);
    chk("t3_ready",   32'(s_if.s_ready), 32'd1);
    send_frame(8'hA0, N, N - 1);

    // 4. rd_done coincides with the commit of frame 2
    do_reset("t4");
    send_frame(8'h40, N, N - 1);
    idle(1, 1'b0);
    send_frame(8'h50, N, N - 1);
    idle(1, 1'b1);
    chk("t4_frame_ready", 32'(frame_ready), 32'd1);
    chk("t4_rd_bank",     32'(rd_bank), 32'd1);
    chk("t4_frame_cnt",   32'(frame_cnt), 32'd2);
    idle(1, 1'b1);
    chk("t4_one_full", 32'(frame_ready), 32'd0);

    // 5. short frame: s_last on the tenth beat
    do_reset("t5");
    send_frame(8'h60, 10, 9);
    chk("t5_err_short", 32'(err_short), 32'd1);
    send_beat(8'h70, 1'b0);
    chk("t5_next_addr", 32'(mem_addr), 32'h10);

    // 6. long frame: no s_last, closes on index N-1; rd_done ignored when idle
    do_reset("t6");
    send_frame(8'h80, N, -1);
    chk("t6_err_long",  32'(err_long), 32'd1);
    chk("t6_not_ready", 32'(frame_ready), 32'd0);
    idle(1, 1'b1);
    chk("t6_rd_bank",     32'(rd_bank), 32'd0);
    chk("t6_frame_ready", 32'(frame_ready), 32'd1);
    idle(1, 1'b0);
    chk("t6_still_full", 32'(frame_ready), 32'd1);
    send_beat(8'h90, 1'b0);
    chk("t6_next_addr", 32'(mem_addr), 32'h10);

    // 7. randomized traffic against the model
    do_reset("t7");
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 11) == 0,
           $urandom_range(0, 5) == 0, acc);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_sram_writer.md
Name: frame_sram_writer

Overview:
Ping-pong frame writer that fills the frame SRAM which the rotation adapter reads. It accepts a raster pixel stream over valid/ready and writes each frame into one of two SRAM banks. It hands each completed bank to the rotation reader through a frame_ready/rd_done handshake. While the reader drains one bank, the writer fills the other, and it stalls the input only when both banks are full.

Parameters:
IMG_W, 1024, pixels per row
IMG_H, 1024, rows per frame
DATA_W, 8, pixel width
PIX_W, 20, index width; must satisfy 2**PIX_W >= IMG_W*IMG_H
FCNT_W, 16, frame counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
s_valid  in  1  input pixel valid
s_ready  out  1  writer can accept a pixel
s_data  in  DATA_W  input pixel, raster order
s_last  in  1  marks the final pixel of a frame
mem_we  out  1  SRAM write strobe, registered
mem_addr  out  PIX_W+1  {bank, pixel index}, registered
mem_wdata  out  DATA_W  SRAM write data, registered
frame_ready  out  1  at least one full bank awaits the reader
rd_bank  out  1  bank the reader must consume
rd_done  in  1  single-cycle pulse: reader finished rd_bank
frame_cnt  out  FCNT_W  frames completed; wraps
err_short  out  1  sticky: s_last arrived before pixel N-1
err_long  out  1  sticky: pixel N-1 arrived without s_last

Behaviour:
- N = IMG_W*IMG_H. Accept = s_valid & s_ready.
- Reset (rst=0, async) forces every register and output to 0: s_ready combinational from reset state = 1; mem_we=0; mem_addr=0; mem_wdata=0; frame_ready=0; rd_bank=0; frame_cnt=0; err_*=0; wr_bank=0; pix_idx=0; full_cnt=0; pend=0.
- Reset mid-frame discards the partial frame; writing restarts at bank 0, index 0.
- Write pipeline, 1 cycle of latency: on an accepted beat, at the next edge mem_we=1, mem_addr={wr_bank,pix_idx}, mem_wdata=s_data. When no beat is accepted, mem_we=0 at the next edge.
- pix_idx increments on each accepted beat.
- Frame close: an accepted beat with pix_idx==N-1, or with s_last=1, closes the frame.
  - At that edge: pix_idx <= 0, wr_bank toggles, pend <= 1.
  - At the following edge, after the SRAM has taken the last write: full_cnt increments, pend <= 0, frame_cnt increments.
- Length errors:
  - s_last=1 with pix_idx<N-1: err_short <= 1. The unwritten addresses keep stale data.
  - pix_idx==N-1 with s_last=0: err_long <= 1.
  - Both flags stay set until reset.
- Per-bank state: EMPTY -> FILLING (first accept) -> PEND (close) -> FULL (next edge) -> EMPTY (rd_done while this bank is rd_bank).
- s_ready = (full_cnt + pend) < 2, combinational from registers.
  - A stall is raised in the cycle after the close that fills the second bank.
  - No beat is ever dropped.
- frame_ready = (full_cnt != 0). rd_bank always points to the oldest FULL bank.
- rd_done handling:
  - Honoured only when frame_ready=1; then full_cnt decrements and rd_bank toggles.
  - rd_done with frame_ready=0 is ignored.
- Simultaneous pend-commit and rd_done: full_cnt unchanged, rd_bank toggles, frame_ready stays 1.
- full_cnt range is 0..2 and can never exceed 2, because s_ready gates the input.
- frame_cnt wraps at 2**FCNT_W.

Decomposition:
- Shared package (frame_pkg):
  - IMG_W, IMG_H and the derived N, PIX_W.
  - DATA_W.
  - Bank-state encoding: EMPTY, FILLING, PEND, FULL.
  - The adapter reuses these constants for its read addressing.
- Sub-module bank_tracker owns full_cnt, pend, rd_bank, the rd_done handshake, the s_ready term and frame_ready.
- The top level keeps the pixel counter, the write pipeline and the error flags.

Test Plan (IMG_W=4, IMG_H=4, N=16, PIX_W=4):
1. Hold rst=0, then release it. Required: s_ready=1, mem_we=0, mem_addr=0, frame_ready=0, frame_cnt=0. Assert rst=0 mid-frame after 5 beats: all outputs return to 0, and the next beat writes mem_addr=0x00.
2. Stream 0x00..0x0F back-to-back, with s_last on 0x0F. Required:
   - mem_we high for 16 cycles, starting one cycle after the first accept.
   - mem_addr 0x00..0x0F, with mem_wdata equal to mem_addr.
   - frame_ready=1 two edges after the last accept, rd_bank=0, frame_cnt=1.
3. Send two frames without rd_done. Required:
   - The second frame writes mem_addr 0x10..0x1F.
   - s_ready=0 from the cycle after the second close, and a third frame stalls.
   - A rd_done pulse sets rd_bank=1, and s_ready=1 next cycle.
   - The third frame writes bank 0, 0x00..0x0F.
4. Align the rd_done pulse with the pend-commit edge of frame 2 while frame 1 is FULL. Required: frame_ready stays 1, rd_bank becomes 1, full_cnt stays 1, frame_cnt=2.
5. Assert s_last on beat 10. Required: err_short=1, the frame closes, and the next beat writes mem_addr 0x10.
6. Send 16 beats with no s_last. Required: err_long=1, the frame still closes at beat 16, and a rd_done pulse with frame_ready=0 leaves rd_bank and full_cnt unchanged.
